hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Decode-stage hazard and multdiv sequencing controller; sits upstream of bypass_control and drives its
//  stall, mul, div and multdiv_rd inputs. Detects load-use hazards (one bubble into D/X) and runs the
//  multicycle mul/div handshake with the multdiv unit. While multdiv is busy it freezes PC, F/D and D/X
//  and bubbles X/M. ISA fields: op[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2].
// PARAMETERS
//  TIMEOUT_CYCLES  40  BUSY cycles before a forced abort (used only with MULTDIV_TIMEOUT_EN)
//  CNT_W           6   width of the BUSY cycle counter; must hold TIMEOUT_CYCLES
// PORTS
//  clock             in   1   pipeline clock, rising edge
//  reset             in   1   synchronous, active-high
//  fd_ir             in   32  instruction in F/D latch
//  dx_ir             in   32  instruction in D/X latch
//  data_resultRDY    in   1   multdiv result valid, 1-cycle pulse
//  data_exception    in   1   multdiv exception, qualified by data_resultRDY
//  stall             out  1   hold PC and F/D enables low
//  stall_dx          out  1   hold D/X enable low (multdiv only)
//  dx_flush          out  1   load nop into D/X this cycle
//  xm_bubble         out  1   load nop into X/M this cycle
//  ctrl_MULT         out  1   1-cycle start pulse to multdiv (mul)
//  ctrl_DIV          out  1   1-cycle start pulse to multdiv (div)
//  mul, div          out  1   registered op type of the in-flight multdiv, held START..DONE
//  multdiv_rd        out  5   latched destination of the in-flight multdiv
//  multdiv_done      out  1   result may advance to X/M this cycle
//  multdiv_exc       out  1   latched exception of the completed op, valid with multdiv_done
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, multdiv_rd=0, counter=0. Reset mid-op aborts and drops the op;
//    no ctrl pulse or done follows.
//  - is_md(dx) = op==00000 & aluop in {00110 mul, 00111 div}.
//  - FSM, registered state:
//    IDLE:  is_md(dx_ir) -> START. Latch rd into multdiv_rd. Latch mul/div.
//    START: ctrl_MULT or ctrl_DIV =1 for exactly this cycle. stall=stall_dx=xm_bubble=1. Go BUSY.
//    BUSY:  stall=stall_dx=xm_bubble=1. Counter increments each cycle.
//           data_resultRDY -> DONE and latch data_exception into multdiv_exc.
//    DONE:  multdiv_done=1 and all stalls 0, so the mul/div leaves D/X this cycle. Go IDLE.
//           No new start is taken in DONE. Back-to-back mul/div therefore starts in the following IDLE cycle.
//  - Latency: data_resultRDY arrives in cycle N -> multdiv_done is asserted in N+1, and stall drops in N+1.
//  - data_resultRDY outside BUSY is ignored.
//  - Load-use (IDLE only): dx op==01000 (lw), dx.rd!=0, and dx.rd equals a source register of fd_ir.
//    Sources by fd op:
//      R-type 00000: rs, rt
//      addi 00101, lw 01000: rs
//      sw 00111: rs, rd
//      bne 00010, blt 00110: rd, rs
//      jr 00100: rd
//      bex 10110: r30
//    On hit: stall=1, dx_flush=1 for exactly one cycle. The next cycle the lw is in X/M and the
//    bypass path covers the hazard.
//  - Register r0 never causes a hazard. fd_ir==0 (nop) never stalls.
//  - Outputs other than mul, div, multdiv_rd and multdiv_exc are combinational from state and registers.
//    mul/div are cleared on returning to IDLE.
// CONFIGURATION
//  MULTDIV_TIMEOUT_EN defined:
//    - In BUSY, when the counter reaches TIMEOUT_CYCLES without data_resultRDY -> DONE with multdiv_exc=1.
//    - Counter clears in IDLE.
//  MULTDIV_TIMEOUT_EN undefined:
//    - No counter logic; BUSY waits indefinitely for data_resultRDY.
// TESTING
//  1. Reset for 2 cycles with a mul in D/X -> all outputs 0 and no ctrl_MULT while reset is high.
//     After release, ctrl_MULT pulses on cycle 2.
//  2. dx_ir = mul r5,r1,r2; data_resultRDY pulsed 33 cycles after ctrl_MULT ->
//     - ctrl_MULT high 1 cycle
//     - stall, stall_dx and xm_bubble high 34 cycles
//     - multdiv_rd=5, mul=1
//     - multdiv_done one cycle after RDY, with stall=0 in that cycle
//  3. dx_ir = lw r3,0(r1), fd_ir = add r4,r3,r2 -> stall=1 and dx_flush=1 for exactly 1 cycle.
//     Repeat with lw r0 -> no stall.
//  4. dx_ir = lw r30, fd_ir = bex -> 1-cycle stall.
//     Repeat with dx_ir = lw r7, fd_ir = sw r7,0(r2) -> 1-cycle stall.
//  5. div followed by mul -> ctrl_DIV pulse, then DONE, then one IDLE cycle, then ctrl_MULT pulse.
//     data_exception=1 on the div RDY -> multdiv_exc=1 with the div's multdiv_done.
//  6. With MULTDIV_TIMEOUT_EN and no RDY -> multdiv_done=1, multdiv_exc=1 after 40 BUSY cycles.
//     Assert reset mid-BUSY -> state returns to IDLE and multdiv_done is never asserted.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Decode-stage hazard and multdiv sequencing controller. Feeds the stall,
//   mul, div and multdiv_rd inputs of bypass_control.
//     - Load-use: a lw in D/X whose rd is read by the instruction in F/D
//       gets one bubble (stall PC/FD, flush D/X) while the FSM is idle.
//     - Multdiv: a mul/div in D/X is handed to the multdiv unit with a
//       one-cycle ctrl_MULT/ctrl_DIV pulse. The pipeline front end (PC, F/D,
//       D/X) is frozen and X/M is bubbled until the result is ready.
//   Optional feature macro: MULTDIV_TIMEOUT_EN
//     defined   -> a BUSY cycle counter forces DONE with multdiv_exc=1 after
//                  TIMEOUT_CYCLES cycles without data_resultRDY.
//     undefined -> BUSY waits for data_resultRDY indefinitely.
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   fd_ir, dx_ir            instructions held in the F/D and D/X latches
//   data_resultRDY          multdiv result valid (1-cycle pulse)
//   data_exception          multdiv exception, qualified by data_resultRDY
//   stall                   hold PC and F/D
//   stall_dx                hold D/X (multdiv only)
//   dx_flush                load a nop into D/X
//   xm_bubble               load a nop into X/M
//   ctrl_MULT, ctrl_DIV     start pulses to the multdiv unit
//   mul, div                registered type of the in-flight op
//   multdiv_rd              latched destination of the in-flight op
//   multdiv_done            result advances to X/M this cycle
//   multdiv_exc             latched exception, valid with multdiv_done
module hazard_stall_unit #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        data_resultRDY,
    input  logic        data_exception,
    output logic        stall,
    output logic        stall_dx,
    output logic        dx_flush,
    output logic        xm_bubble,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        mul,
    output logic        div,
    output logic [4:0]  multdiv_rd,
    output logic        multdiv_done,
    output logic        multdiv_exc
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [4:0] REG_STAT = 5'd30;

    // Counter must be able to represent the timeout value.
    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t state, state_nxt;

    // ---------------- decode ----------------
    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_aluop;
    logic       dx_is_md;

    assign fd_op    = fd_ir[31:27];
    assign fd_rd    = fd_ir[26:22];
    assign fd_rs    = fd_ir[21:17];
    assign fd_rt    = fd_ir[16:12];
    assign dx_op    = dx_ir[31:27];
    assign dx_rd    = dx_ir[26:22];
    assign dx_aluop = dx_ir[6:2];
    assign dx_is_md = (dx_op == OP_RTYPE) && ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

    // Fields not needed for hazard decisions.
    logic unused_bits;
    assign unused_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    // Up to two source registers read by the F/D instruction.
    logic [4:0] src_a, src_b;
    logic       use_a, use_b;

    always_comb begin
        src_a = 5'd0;
        src_b = 5'd0;
        use_a = 1'b0;
        use_b = 1'b0;
        case (fd_op)
            OP_RTYPE:        begin src_a = fd_rs;    src_b = fd_rt; use_a = 1'b1; use_b = 1'b1; end
            OP_ADDI, OP_LW:  begin src_a = fd_rs;    use_a = 1'b1; end
            OP_SW:           begin src_a = fd_rs;    src_b = fd_rd; use_a = 1'b1; use_b = 1'b1; end
            OP_BNE, OP_BLT:  begin src_a = fd_rd;    src_b = fd_rs; use_a = 1'b1; use_b = 1'b1; end
            OP_JR:           begin src_a = fd_rd;    use_a = 1'b1; end
            OP_BEX:          begin src_a = REG_STAT; use_a = 1'b1; end
            default:         ;
        endcase
    end

    // dx_rd != 0 keeps r0 out; an all-zero F/D word is a nop and never stalls.
    logic load_use;
    assign load_use = (state == IDLE) && (dx_op == OP_LW) && (dx_rd != 5'd0) && (fd_ir != 32'd0)
                    && ((use_a && (src_a == dx_rd)) || (use_b && (src_b == dx_rd)));

    // ---------------- optional timeout ----------------
    logic timeout;
`ifdef MULTDIV_TIMEOUT_EN
    logic [CNT_W-1:0] busy_cnt;

    // Counts BUSY cycles already spent; cleared outside BUSY.
    always_ff @(posedge clock) begin
        if (reset || (state != BUSY))
            busy_cnt <= '0;
        else
            busy_cnt <= busy_cnt + 1'b1;
    end

    // Fires on the TIMEOUT_CYCLES-th BUSY cycle.
    assign timeout = (state == BUSY) && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dx_is_md) state_nxt = START;
            START:   state_nxt = BUSY;
            BUSY:    if (data_resultRDY || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;   // no start here; back-to-back waits one IDLE cycle
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    logic md_hold;

    always_comb begin
        md_hold      = (state == START) || (state == BUSY);
        stall        = md_hold || load_use;
        stall_dx     = md_hold;
        xm_bubble    = md_hold;
        dx_flush     = load_use;
        ctrl_MULT    = (state == START) && mul;
        ctrl_DIV     = (state == START) && div;
        multdiv_done = (state == DONE);
    end

    // ---------------- in-flight op registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            mul         <= 1'b0;
            div         <= 1'b0;
            multdiv_rd  <= 5'd0;
            multdiv_exc <= 1'b0;
        end else begin
            case (state)
                IDLE: if (dx_is_md) begin
                    mul        <= (dx_aluop == ALU_MUL);
                    div        <= (dx_aluop == ALU_DIV);
                    multdiv_rd <= dx_rd;
                end
                BUSY: begin
                    // A real result wins over a timeout in the same cycle.
                    if (data_resultRDY)
                        multdiv_exc <= data_exception;
                    else if (timeout)
                        multdiv_exc <= 1'b1;
                end
                DONE: begin
                    mul         <= 1'b0;
                    div         <= 1'b0;
                    multdiv_exc <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit
//   Per-cycle stimulus lists; each cycle's expected output vector is pushed
//   to a scoreboard queue as the inputs are driven and popped at the
//   following negedge for comparison.
module tb_hazard_stall_unit;

    logic        clock, reset;
    logic [31:0] fd_ir, dx_ir;
    logic        data_resultRDY, data_exception;
    logic        stall, stall_dx, dx_flush, xm_bubble, ctrl_MULT, ctrl_DIV;
    logic        mul, div, multdiv_done, multdiv_exc;
    logic [4:0]  multdiv_rd;

    hazard_stall_unit dut (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
        .data_resultRDY(data_resultRDY), .data_exception(data_exception),
        .stall(stall), .stall_dx(stall_dx), .dx_flush(dx_flush), .xm_bubble(xm_bubble),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .mul(mul), .div(div),
        .multdiv_rd(multdiv_rd), .multdiv_done(multdiv_done), .multdiv_exc(multdiv_exc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Flag order: stall stall_dx dx_flush xm_bubble ctrl_MULT ctrl_DIV mul div done exc
    localparam logic [9:0] F_STALL = 10'b10_0000_0000;
    localparam logic [9:0] F_SDX   = 10'b01_0000_0000;
    localparam logic [9:0] F_FLUSH = 10'b00_1000_0000;
    localparam logic [9:0] F_XMB   = 10'b00_0100_0000;
    localparam logic [9:0] F_CM    = 10'b00_0010_0000;
    localparam logic [9:0] F_CD    = 10'b00_0001_0000;
    localparam logic [9:0] F_MUL   = 10'b00_0000_1000;
    localparam logic [9:0] F_DIV   = 10'b00_0000_0100;
    localparam logic [9:0] F_DONE  = 10'b00_0000_0010;
    localparam logic [9:0] F_EXC   = 10'b00_0000_0001;
    localparam logic [9:0] MDS     = F_STALL | F_SDX | F_XMB;
    localparam logic [9:0] LUS     = F_STALL | F_FLUSH;
    localparam logic [9:0] NONE    = 10'b0;

    typedef struct {
        logic        rst;
        logic [31:0] fd;
        logic [31:0] dx;
        logic        rdy;
        logic        exc;
        logic [14:0] exp;
    } cyc_t;

    cyc_t        stim[$];
    logic [14:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    wire [14:0] obs = {stall, stall_dx, dx_flush, xm_bubble, ctrl_MULT, ctrl_DIV,
                       mul, div, multdiv_done, multdiv_exc, multdiv_rd};

    function automatic logic [31:0] r_ins(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt, logic [4:0] alu);
        return {5'd0, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] i_ins(logic [4:0] op, logic [4:0] rd, logic [4:0] rs, logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic cyc_t cy(logic rst, logic [31:0] fd, logic [31:0] dx, logic rdy, logic exc,
                                logic [9:0] fl, logic [4:0] rd);
        cyc_t c;
        c.rst = rst; c.fd = fd; c.dx = dx; c.rdy = rdy; c.exc = exc; c.exp = {fl, rd};
        return c;
    endfunction

    function automatic logic [31:0] mul_i(logic [4:0] rd);
        return r_ins(rd, 5'd1, 5'd2, 5'b00110);
    endfunction

    function automatic logic [31:0] div_i(logic [4:0] rd);
        return r_ins(rd, 5'd3, 5'd4, 5'b00111);
    endfunction

    function automatic logic [31:0] lw_i(logic [4:0] rd);
        return i_ins(5'b01000, rd, 5'd1, 17'd0);
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset;
        cyc_t cur; logic [14:0] e; int k = 0;
        stim.push_back(cy(1, 0, mul_i(5), 0, 0, NONE, 0));
        stim.push_back(cy(1, 0, mul_i(5), 0, 0, NONE, 0));
        stim.push_back(cy(0, 0, mul_i(5), 0, 0, NONE, 0));             // cycle 1: IDLE
        stim.push_back(cy(0, 0, mul_i(5), 0, 0, MDS | F_CM | F_MUL, 5)); // cycle 2: START
        stim.push_back(cy(1, 0, mul_i(5), 0, 0, MDS | F_MUL, 5));       // BUSY, reset sampled
        stim.push_back(cy(0, 0, 0, 0, 0, NONE, 0));
        stim.push_back(cy(0, 0, 0, 0, 0, NONE, 0));
        while (stim.size() > 0) begin
            cur = stim.pop_front();
            reset = cur.rst; fd_ir = cur.fd; dx_ir = cur.dx;
            data_resultRDY = cur.rdy; data_exception = cur.exc;
            exp_q.push_back(cur.exp);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %b required %b", k, obs, e);
            end
            k++;
            @(posedge clock); #1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mul;
        cyc_t cur; logic [14:0] e; int k = 0;
        stim.push_back(cy(0, 0, mul_i(5), 0, 0, NONE, 0));
        stim.push_back(cy(0, 0, mul_i(5), 0, 0, MDS | F_CM | F_MUL, 5));
        for (int i = 0; i < 32; i++)
            stim.push_back(cy(0, 0, mul_i(5), 0, 0, MDS | F_MUL, 5));
        stim.push_back(cy(0, 0, mul_i(5), 1, 0, MDS | F_MUL, 5));      // RDY 33 cycles after ctrl_MULT
        stim.push_back(cy(0, 0, mul_i(5), 0, 0, F_DONE | F_MUL, 5));    // DONE, stall drops
        stim.push_back(cy(0, 0, 0, 0, 0, NONE, 5));
        stim.push_back(cy(0, 0, 0, 1, 1, NONE, 5));                     // stray RDY in IDLE
        stim.push_back(cy(0, 0, 0, 0, 0, NONE, 5));
        stim.push_back(cy(0, 0, 0, 0, 0, NONE, 5));
        while (stim.size() > 0) begin
            cur = stim.pop_front();
            reset = cur.rst; fd_ir = cur.fd; dx_ir = cur.dx;
            data_resultRDY = cur.rdy; data_exception = cur.exc;
            exp_q.push_back(cur.exp);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL mul cyc%0d: got %b required %b", k, obs, e);
            end
            k++;
            @(posedge clock); #1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_load_use;
        cyc_t cur; logic [14:0] e; int k = 0;
        logic [31:0] add_r3 = r_ins(5'd4, 5'd3, 5'd2, 5'b00000);
        stim.push_back(cy(0, add_r3, lw_i(3), 0, 0, LUS, 5));
        stim.push_back(cy(0, add_r3, 0, 0, 0, NONE, 5));                // lw moved on
        stim.push_back(cy(0, r_ins(5'd4, 5'd0, 5'd2, 5'b00000), lw_i(0), 0, 0, NONE, 5));
        stim.push_back(cy(0, 0, lw_i(3), 0, 0, NONE, 5));               // nop in F/D
        stim.push_back(cy(0, r_ins(5'd4, 5'd1, 5'd3, 5'b00000), lw_i(3), 0, 0, LUS, 5));
        stim.push_back(cy(0, 0, 0, 0, 0, NONE, 5));
        stim.push_back(cy(0, i_ins(5'b00101, 5'd3, 5'd1, 17'd5), lw_i(3), 0, 0, NONE, 5)); // addi rd only
        stim.push_back(cy(0, i_ins(5'b00101, 5'd9, 5'd3, 17'd5), lw_i(3), 0, 0, LUS, 5));
        stim.push_back(cy(0, 0, 0, 0, 0, NONE, 5));
        while (stim.size() > 0) begin
            cur = stim.pop_front();
            reset = cur.rst; fd_ir = cur.fd; dx_ir = cur.dx;
            data_resultRDY = cur.rdy; data_exception = cur.exc;
            exp_q.push_back(cur.exp);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL load_use cyc%0d: got %b required %b", k, obs, e);
            end
            k++;
            @(posedge clock); #1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_src_kinds;
        cyc_t cur; logic [14:0] e; int k = 0;
        stim.push_back(cy(0, i_ins(5'b10110, 5'd0, 5'd0, 17'd100), lw_i(30), 0, 0, LUS, 5)); // bex
        stim.push_back(cy(0, i_ins(5'b10110, 5'd0, 5'd0, 17'd100), 0, 0, 0, NONE, 5));
        stim.push_back(cy(0, i_ins(5'b00111, 5'd7, 5'd2, 17'd0), lw_i(7), 0, 0, LUS, 5));    // sw r7,0(r2)
        stim.push_back(cy(0, i_ins(5'b00111, 5'd7, 5'd2, 17'd0), 0, 0, 0, NONE, 5));
        stim.push_back(cy(0, i_ins(5'b00010, 5'd7, 5'd1, 17'd4), lw_i(7), 0, 0, LUS, 5));    // bne rd
        stim.push_back(cy(0, i_ins(5'b00110, 5'd1, 5'd7, 17'd4), lw_i(7), 0, 0, LUS, 5));    // blt rs
        stim.push_back(cy(0, i_ins(5'b00100, 5'd7, 5'd0, 17'd0), lw_i(7), 0, 0, LUS, 5));    // jr rd
        stim.push_back(cy(0, i_ins(5'b00100, 5'd1, 5'd7, 17'd0), lw_i(7), 0, 0, NONE, 5));   // jr ignores rs
        stim.push_back(cy(0, i_ins(5'b10110, 5'd0, 5'd0, 17'd100), lw_i(29), 0, 0, NONE, 5));
        while (stim.size() > 0) begin
            cur = stim.pop_front();
            reset = cur.rst; fd_ir = cur.fd; dx_ir = cur.dx;
            data_resultRDY = cur.rdy; data_exception = cur.exc;
            exp_q.push_back(cur.exp);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL src_kinds cyc%0d: got %b required %b", k, obs, e);
            end
            k++;
            @(posedge clock); #1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back;
        cyc_t cur; logic [14:0] e; int k = 0;
        stim.push_back(cy(0, 0, div_i(9), 0, 0, NONE, 5));
        stim.push_back(cy(0, 0, div_i(9), 0, 0, MDS | F_CD | F_DIV, 9));
        stim.push_back(cy(0, 0, div_i(9), 0, 1, MDS | F_DIV, 9));       // exception without RDY
        stim.push_back(cy(0, 0, div_i(9), 0, 0, MDS | F_DIV, 9));
        stim.push_back(cy(0, 0, div_i(9), 1, 1, MDS | F_DIV, 9));
        stim.push_back(cy(0, 0, div_i(9), 0, 0, F_DONE | F_DIV | F_EXC, 9));
        stim.push_back(cy(0, 0, mul_i(12), 0, 0, NONE, 9));             // IDLE gap
        stim.push_back(cy(0, 0, mul_i(12), 0, 0, MDS | F_CM | F_MUL, 12));
        stim.push_back(cy(0, 0, mul_i(12), 1, 0, MDS | F_MUL, 12));
        stim.push_back(cy(0, 0, mul_i(12), 0, 1, F_DONE | F_MUL, 12));
        stim.push_back(cy(0, 0, 0, 0, 0, NONE, 12));
        while (stim.size() > 0) begin
            cur = stim.pop_front();
            reset = cur.rst; fd_ir = cur.fd; dx_ir = cur.dx;
            data_resultRDY = cur.rdy; data_exception = cur.exc;
            exp_q.push_back(cur.exp);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d: got %b required %b", k, obs, e);
            end
            k++;
            @(posedge clock); #1;
        end
    endtask

`ifdef MULTDIV_TIMEOUT_EN
    // ------------------------------------------------------------------
    task automatic test_timeout;
        cyc_t cur; logic [14:0] e; int k = 0;
        stim.push_back(cy(0, 0, mul_i(6), 0, 0, NONE, 12));
        stim.push_back(cy(0, 0, mul_i(6), 0, 0, MDS | F_CM | F_MUL, 6));
        for (int i = 0; i < 40; i++)
            stim.push_back(cy(0, 0, mul_i(6), 0, 0, MDS | F_MUL, 6));
        stim.push_back(cy(0, 0, mul_i(6), 0, 0, F_DONE | F_MUL | F_EXC, 6));
        stim.push_back(cy(0, 0, 0, 0, 0, NONE, 6));
        while (stim.size() > 0) begin
            cur = stim.pop_front();
            reset = cur.rst; fd_ir = cur.fd; dx_ir = cur.dx;
            data_resultRDY = cur.rdy; data_exception = cur.exc;
            exp_q.push_back(cur.exp);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL timeout cyc%0d: got %b required %b", k, obs, e);
            end
            k++;
            @(posedge clock); #1;
        end
    endtask
`endif

    // ------------------------------------------------------------------
    task automatic test_abort;
        cyc_t cur; logic [14:0] e; int k = 0;
        int busy_n;
`ifdef MULTDIV_TIMEOUT_EN
        busy_n = 5;
`else
        busy_n = 45;   // past any timeout value: must keep waiting
`endif
        stim.push_back(cy(0, 0, mul_i(6), 0, 0, NONE, 0));
        stim.push_back(cy(0, 0, mul_i(6), 0, 0, MDS | F_CM | F_MUL, 6));
        for (int i = 0; i < busy_n; i++)
            stim.push_back(cy(0, 0, mul_i(6), 0, 0, MDS | F_MUL, 6));
        stim.push_back(cy(1, 0, mul_i(6), 0, 0, MDS | F_MUL, 6));       // reset mid-BUSY
        stim.push_back(cy(0, 0, 0, 1, 1, NONE, 0));                     // late RDY ignored
        for (int i = 0; i < 3; i++)
            stim.push_back(cy(0, 0, 0, 0, 0, NONE, 0));
        while (stim.size() > 0) begin
            cur = stim.pop_front();
            reset = cur.rst; fd_ir = cur.fd; dx_ir = cur.dx;
            data_resultRDY = cur.rdy; data_exception = cur.exc;
            exp_q.push_back(cur.exp);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL abort cyc%0d: got %b required %b", k, obs, e);
            end
            k++;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset = 1'b1; fd_ir = '0; dx_ir = '0;
        data_resultRDY = 1'b0; data_exception = 1'b0;
        @(posedge clock); #1;
        test_reset();
        test_mul();
        test_load_use();
        test_src_kinds();
        test_back_to_back();
`ifdef MULTDIV_TIMEOUT_EN
        test_timeout();
        // Park at a known multdiv_rd value before the abort run.
        reset = 1'b1; @(posedge clock); #1;
`else
        reset = 1'b1; @(posedge clock); #1;
`endif
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
